apuracao_votos: RTL and testbench
=================================

Name: apuracao_votos

Overview:
Day-phase vote tally for PoliLobinho. Sits downstream of the player-button converter and the control unit. It consumes the chosen-player index together with the per-vote action pulse from the control unit. It walks through every living voter, accumulates votes per target, and then resolves the eliminated player or a tie. The result and a done flag go back to the control unit and the datapath.

Parameters:
N_JOGADORES, 5, number of players; player indices are 1..N_JOGADORES, and 0 means "none".
W_JOG, 3, width of a player index.
W_VOTO, 3, width of each per-player vote counter; must hold N_JOGADORES.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
iniciar  input  1  one-cycle pulse; starts a vote round and samples vivos.
vivos  input  N_JOGADORES  alive mask; bit i-1 set means player i is alive.
votar  input  1  one-cycle pulse; the current voter casts a vote for jogador_escolhido.
jogador_escolhido  input  W_JOG  target index from the button converter.
eleitor_atual  output  W_JOG  index of the voter expected to vote; 0 when not collecting.
coletando  output  1  high in state COLETA.
voto_invalido  output  1  one-cycle pulse when a votar pulse is rejected.
pronto  output  1  high in state RESULTADO.
eliminado  output  W_JOG  winning target; 0 on a tie, with no votes, or before a result.
empate  output  1  high in RESULTADO when two or more targets share the maximum, which is nonzero.
votos_max  output  W_VOTO  vote count of the maximum; for display.

Behaviour:
- Reset takes effect on the next edge when reset=1, and overrides all other inputs.
  - State goes to OCIOSO; tallies, vivos_reg and eleitor_atual are cleared.
  - All outputs are 0.
- FSM states: OCIOSO, COLETA, APURA, RESULTADO.
- OCIOSO --iniciar--> COLETA.
  - Latches vivos into vivos_reg and clears all tallies.
  - eleitor_atual is set to the lowest alive index.
  - If vivos=0, go straight to RESULTADO with eliminado=0 and empate=0.
- COLETA, on votar:
  - The vote is valid if jogador_escolhido is in 1..N_JOGADORES and that target is alive in vivos_reg. Self-votes are allowed.
  - Valid vote: tally[target]++ on that edge, and eleitor_atual advances to the next higher alive index.
  - If eleitor_atual was the highest alive index, go to APURA on that edge instead.
  - Invalid vote: nothing changes and voto_invalido=1 for exactly the next cycle.
  - No votar means hold.
- APURA: scans targets 1..N_JOGADORES, one per cycle, so it takes N_JOGADORES cycles.
  - Keeps a running max, an argmax and a tie flag.
  - A strict greater value replaces the max and clears the tie flag.
  - An equal, nonzero value sets the tie flag.
  - After the last target, go to RESULTADO.
- RESULTADO:
  - pronto=1.
  - eliminado = argmax if max>0 and no tie, else 0.
  - empate = tie flag and max>0.
  - Outputs hold until iniciar or reset.
- iniciar in any state other than OCIOSO restarts the round: same actions as OCIOSO --iniciar-->, and pronto drops on that edge.
- If iniciar and votar arrive in the same cycle, iniciar wins and the vote is discarded.
- votar outside COLETA is ignored and does not raise voto_invalido.
- Tallies saturate at 2^W_VOTO-1 and never wrap.
- Latency from the last valid vote to pronto=1 is N_JOGADORES+1 cycles.

Optional Feature:
Macro: POLILOBINHO_ABSTENCAO_EN
- Defined: votar with jogador_escolhido=0 is an abstention. It is a valid vote: the voter advances and no tally changes.
- Not defined: jogador_escolhido=0 is an invalid vote and raises voto_invalido.

Decomposition:
- Package polilobinho_pkg holds:
  - the state enum for this block's FSM;
  - N_JOGADORES and W_JOG shared with the datapath;
  - the constant JOGADOR_NENHUM=0.
- One sub-module, proximo_vivo: combinational priority search.
  - Inputs: alive mask and current index.
  - Outputs: next higher alive index and an "is last" flag.
  - With current=0 it returns the lowest alive index.
  - Used for both the start and the advance of eleitor_atual.

Test Plan:
1. vivos=5'b11111, iniciar; five votar pulses with targets 3,3,1,3,2 -> after 6 more cycles pronto=1, eliminado=3, votos_max=3, empate=0.
2. vivos=5'b01111; targets 1,2,1,2 -> eliminado=0, empate=1, votos_max=2.
3. vivos=5'b10101; eleitor_atual sequence 1,3,5; a votar with target 2 (dead) -> voto_invalido pulses, eleitor_atual stays 1. Target 6 gives the same result.
4. Mid-COLETA after 2 votes, iniciar together with votar -> tallies cleared, eleitor_atual=1, the simultaneous vote is discarded. Reset mid-APURA -> all outputs 0 on the next cycle.
5. vivos=0, iniciar -> pronto=1 on the next cycle, eliminado=0, empate=0.
6. Target 0 submitted -> with POLILOBINHO_ABSTENCAO_EN the voter advances and no tally changes; all-abstain gives eliminado=0, empate=0. Without the macro, voto_invalido=1.

Source files
------------

// File: rtl/polilobinho_pkg.sv
// Shared PoliLobinho constants and the vote-tally FSM state type.
package polilobinho_pkg;

    localparam int N_JOGADORES = 5;
    localparam int W_JOG       = 3;

    localparam logic [W_JOG-1:0] JOGADOR_NENHUM = '0;

    typedef enum logic [1:0] {
        OCIOSO,
        COLETA,
        APURA,
        RESULTADO
    } estado_apuracao_t;

endpackage

// File: rtl/apuracao_votos_proximo_vivo.sv
// Priority search for the next alive player above a given index.
// An index of 0 yields the lowest alive player; "last" means none above.
module proximo_vivo
    import polilobinho_pkg::*;
(
    input  logic [N_JOGADORES-1:0] vivos_i,
    input  logic [W_JOG-1:0]       atual_i,
    output logic [W_JOG-1:0]       proximo_o,
    output logic                   ultimo_o
);

    always_comb begin
        proximo_o = JOGADOR_NENHUM;
        // Descending scan so the lowest qualifying index wins.
        for (int i = N_JOGADORES; i >= 1; i--) begin
            if (vivos_i[i-1] && (W_JOG'(i) > atual_i)) begin
                proximo_o = W_JOG'(i);
            end
        end
        ultimo_o = (proximo_o == JOGADOR_NENHUM);
    end

endmodule

// File: rtl/apuracao_votos.sv
// Day-phase vote tally: collects one vote per living player, then resolves.
// Build with POLILOBINHO_ABSTENCAO_EN to accept target 0 as an abstention.
module apuracao_votos
    import polilobinho_pkg::*;
#(
    parameter int W_VOTO = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic [N_JOGADORES-1:0] vivos,
    input  logic                   votar,
    input  logic [W_JOG-1:0]       jogador_escolhido,
    output logic [W_JOG-1:0]       eleitor_atual,
    output logic                   coletando,
    output logic                   voto_invalido,
    output logic                   pronto,
    output logic [W_JOG-1:0]       eliminado,
    output logic                   empate,
    output logic [W_VOTO-1:0]      votos_max
);

    localparam logic [W_VOTO-1:0] VOTO_SAT = {W_VOTO{1'b1}};

    estado_apuracao_t       estado_q;
    logic [N_JOGADORES-1:0] vivos_q;
    logic [W_VOTO-1:0]      tally_q [N_JOGADORES];
    logic [W_JOG-1:0]       eleitor_q;
    logic                   invalido_q;
    logic [W_JOG-1:0]       scan_q;
    logic [W_VOTO-1:0]      max_q;
    logic [W_JOG-1:0]       arg_q;
    logic                   tie_q;

    logic [N_JOGADORES-1:0] busca_vivos;
    logic [W_JOG-1:0]       busca_atual;
    logic [W_JOG-1:0]       proximo;
    logic                   ultimo;
    logic                   alvo_vivo;
    logic                   voto_ok;
    logic [W_VOTO-1:0]      valor_scan;

    // Start and advance share one search: iniciar looks from 0 in the new mask.
    assign busca_vivos = iniciar ? vivos : vivos_q;
    assign busca_atual = iniciar ? JOGADOR_NENHUM : eleitor_q;

    proximo_vivo u_proximo_vivo (
        .vivos_i   (busca_vivos),
        .atual_i   (busca_atual),
        .proximo_o (proximo),
        .ultimo_o  (ultimo)
    );

    always_comb begin
        alvo_vivo  = 1'b0;
        valor_scan = '0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            if (jogador_escolhido == W_JOG'(i + 1) && vivos_q[i]) begin
                alvo_vivo = 1'b1;
            end
            if (scan_q == W_JOG'(i + 1)) begin
                valor_scan = tally_q[i];
            end
        end
`ifdef POLILOBINHO_ABSTENCAO_EN
        voto_ok = alvo_vivo || (jogador_escolhido == JOGADOR_NENHUM);
`else
        voto_ok = alvo_vivo;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            vivos_q    <= '0;
            eleitor_q  <= JOGADOR_NENHUM;
            invalido_q <= 1'b0;
            scan_q     <= W_JOG'(1);
            max_q      <= '0;
            arg_q      <= JOGADOR_NENHUM;
            tie_q      <= 1'b0;
            for (int i = 0; i < N_JOGADORES; i++) tally_q[i] <= '0;
        end else begin
            invalido_q <= 1'b0;
            if (iniciar) begin
                vivos_q   <= vivos;
                eleitor_q <= proximo;
                scan_q    <= W_JOG'(1);
                max_q     <= '0;
                arg_q     <= JOGADOR_NENHUM;
                tie_q     <= 1'b0;
                for (int i = 0; i < N_JOGADORES; i++) tally_q[i] <= '0;
                estado_q  <= (vivos == '0) ? RESULTADO : COLETA;
            end else begin
                unique case (estado_q)
                    COLETA: begin
                        if (votar && voto_ok) begin
                            for (int i = 0; i < N_JOGADORES; i++) begin
                                if (jogador_escolhido == W_JOG'(i + 1) &&
                                    tally_q[i] != VOTO_SAT) begin
                                    tally_q[i] <= tally_q[i] + 1'b1;
                                end
                            end
                            if (ultimo) begin
                                estado_q  <= APURA;
                                eleitor_q <= JOGADOR_NENHUM;
                            end else begin
                                eleitor_q <= proximo;
                            end
                        end else if (votar) begin
                            invalido_q <= 1'b1;
                        end
                    end
                    APURA: begin
                        if (valor_scan > max_q) begin
                            max_q <= valor_scan;
                            arg_q <= scan_q;
                            tie_q <= 1'b0;
                        end else if (valor_scan == max_q && valor_scan != '0) begin
                            tie_q <= 1'b1;
                        end
                        scan_q <= scan_q + 1'b1;
                        if (scan_q == W_JOG'(N_JOGADORES)) begin
                            estado_q <= RESULTADO;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign coletando     = (estado_q == COLETA);
    assign pronto        = (estado_q == RESULTADO);
    assign eleitor_atual = coletando ? eleitor_q : JOGADOR_NENHUM;
    assign voto_invalido = invalido_q;
    assign votos_max     = max_q;
    assign empate        = pronto && tie_q && (max_q != '0);
    assign eliminado     = (pronto && !tie_q && max_q != '0) ? arg_q : JOGADOR_NENHUM;

endmodule

// File: tb/tb_apuracao_votos.sv
// Self-checking bench for apuracao_votos: directed scenarios plus random rounds.
`timescale 1ns/1ps
module tb_apuracao_votos;

    localparam int N = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [4:0] vivos = '0;
    logic       votar = 1'b0;
    logic [2:0] jogador_escolhido = '0;
    logic [2:0] eleitor_atual;
    logic       coletando;
    logic       voto_invalido;
    logic       pronto;
    logic [2:0] eliminado;
    logic       empate;
    logic [2:0] votos_max;

    int checks = 0;
    int errors = 0;

    apuracao_votos dut (
        .clock             (clock),
        .reset             (reset),
        .iniciar           (iniciar),
        .vivos             (vivos),
        .votar             (votar),
        .jogador_escolhido (jogador_escolhido),
        .eleitor_atual     (eleitor_atual),
        .coletando         (coletando),
        .voto_invalido     (voto_invalido),
        .pronto            (pronto),
        .eliminado         (eliminado),
        .empate            (empate),
        .votos_max         (votos_max)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [4:0] v);
        iniciar = 1'b1;
        vivos   = v;
        cyc();
        iniciar = 1'b0;
    endtask

    task automatic vote(input logic [2:0] t);
        votar             = 1'b1;
        jogador_escolhido = t;
        cyc();
        votar = 1'b0;
    endtask

    task automatic wait_pronto(output int n);
        n = 0;
        while (!pronto && n < 20) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        checks++;
        if ({eleitor_atual, coletando, voto_invalido, pronto, eliminado, empate, votos_max} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                     {eleitor_atual, coletando, voto_invalido, pronto, eliminado, empate, votos_max});
        end
    endtask

    task automatic test_majority();
        int n;
        logic [2:0] alvos [5] = '{3'd3, 3'd3, 3'd1, 3'd3, 3'd2};
        start(5'b11111);
        checks++;
        if (eleitor_atual !== 3'd1 || coletando !== 1'b1) begin
            errors++;
            $display("FAIL t1_start eleitor=%0d col=%b want 1 1", eleitor_atual, coletando);
        end
        for (int i = 0; i < 5; i++) vote(alvos[i]);
        checks++;
        if (pronto !== 1'b0) begin
            errors++;
            $display("FAIL t1_early_pronto got %b want 0", pronto);
        end
        wait_pronto(n);
        checks++;
        if (n != N) begin
            errors++;
            $display("FAIL t1_latency got %0d want %0d", n, N);
        end
        checks++;
        if (eliminado !== 3'd3 || votos_max !== 3'd3 || empate !== 1'b0) begin
            errors++;
            $display("FAIL t1_result elim=%0d max=%0d emp=%b want 3 3 0",
                     eliminado, votos_max, empate);
        end
        vote(3'd2);
        checks++;
        if (voto_invalido !== 1'b0 || pronto !== 1'b1 || eliminado !== 3'd3) begin
            errors++;
            $display("FAIL t1_vote_outside inv=%b pronto=%b elim=%0d want 0 1 3",
                     voto_invalido, pronto, eliminado);
        end
    endtask

    task automatic test_tie();
        int n;
        start(5'b01111);
        vote(3'd1);
        vote(3'd2);
        vote(3'd1);
        vote(3'd2);
        wait_pronto(n);
        checks++;
        if (pronto !== 1'b1 || eliminado !== 3'd0 || empate !== 1'b1 || votos_max !== 3'd2) begin
            errors++;
            $display("FAIL t2_tie pronto=%b elim=%0d emp=%b max=%0d want 1 0 1 2",
                     pronto, eliminado, empate, votos_max);
        end
    endtask

    task automatic test_invalid();
        int n;
        start(5'b10101);
        vote(3'd2);
        checks++;
        if (voto_invalido !== 1'b1 || eleitor_atual !== 3'd1) begin
            errors++;
            $display("FAIL t3_dead inv=%b eleitor=%0d want 1 1", voto_invalido, eleitor_atual);
        end
        cyc();
        checks++;
        if (voto_invalido !== 1'b0) begin
            errors++;
            $display("FAIL t3_pulse_width inv=%b want 0", voto_invalido);
        end
        vote(3'd6);
        checks++;
        if (voto_invalido !== 1'b1 || eleitor_atual !== 3'd1) begin
            errors++;
            $display("FAIL t3_range inv=%b eleitor=%0d want 1 1", voto_invalido, eleitor_atual);
        end
        vote(3'd1);
        checks++;
        if (eleitor_atual !== 3'd3 || voto_invalido !== 1'b0) begin
            errors++;
            $display("FAIL t3_adv3 eleitor=%0d inv=%b want 3 0", eleitor_atual, voto_invalido);
        end
        vote(3'd5);
        checks++;
        if (eleitor_atual !== 3'd5) begin
            errors++;
            $display("FAIL t3_adv5 eleitor=%0d want 5", eleitor_atual);
        end
        vote(3'd1);
        checks++;
        if (eleitor_atual !== 3'd0 || coletando !== 1'b0) begin
            errors++;
            $display("FAIL t3_done eleitor=%0d col=%b want 0 0", eleitor_atual, coletando);
        end
        wait_pronto(n);
        checks++;
        if (eliminado !== 3'd1 || votos_max !== 3'd2 || empate !== 1'b0) begin
            errors++;
            $display("FAIL t3_result elim=%0d max=%0d emp=%b want 1 2 0",
                     eliminado, votos_max, empate);
        end
    endtask

    task automatic test_restart_and_reset();
        int n;
        logic [2:0] alvos [5] = '{3'd3, 3'd4, 3'd5, 3'd1, 3'd1};
        start(5'b11111);
        vote(3'd2);
        vote(3'd2);
        iniciar           = 1'b1;
        votar             = 1'b1;
        vivos             = 5'b11111;
        jogador_escolhido = 3'd3;
        cyc();
        iniciar = 1'b0;
        votar   = 1'b0;
        checks++;
        if (eleitor_atual !== 3'd1 || coletando !== 1'b1 || voto_invalido !== 1'b0) begin
            errors++;
            $display("FAIL t4_restart eleitor=%0d col=%b inv=%b want 1 1 0",
                     eleitor_atual, coletando, voto_invalido);
        end
        for (int i = 0; i < 5; i++) vote(alvos[i]);
        wait_pronto(n);
        checks++;
        if (eliminado !== 3'd1 || votos_max !== 3'd2 || empate !== 1'b0) begin
            errors++;
            $display("FAIL t4_cleared elim=%0d max=%0d emp=%b want 1 2 0",
                     eliminado, votos_max, empate);
        end
        start(5'b11111);
        for (int i = 0; i < 5; i++) vote(3'd4);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if ({eleitor_atual, coletando, voto_invalido, pronto, eliminado, empate, votos_max} !== '0) begin
            errors++;
            $display("FAIL t4_reset_apura got %b want 0",
                     {eleitor_atual, coletando, voto_invalido, pronto, eliminado, empate, votos_max});
        end
    endtask

    task automatic test_nobody_alive();
        start(5'b00000);
        checks++;
        if (pronto !== 1'b1 || eliminado !== 3'd0 || empate !== 1'b0 || coletando !== 1'b0) begin
            errors++;
            $display("FAIL t5_empty pronto=%b elim=%0d emp=%b col=%b want 1 0 0 0",
                     pronto, eliminado, empate, coletando);
        end
    endtask

    task automatic test_abstention();
        int n;
        start(5'b11111);
        vote(3'd0);
`ifdef POLILOBINHO_ABSTENCAO_EN
        checks++;
        if (voto_invalido !== 1'b0 || eleitor_atual !== 3'd2) begin
            errors++;
            $display("FAIL t6_abstain inv=%b eleitor=%0d want 0 2", voto_invalido, eleitor_atual);
        end
        for (int i = 0; i < 4; i++) vote(3'd0);
`else
        checks++;
        if (voto_invalido !== 1'b1 || eleitor_atual !== 3'd1) begin
            errors++;
            $display("FAIL t6_zero_invalid inv=%b eleitor=%0d want 1 1", voto_invalido, eleitor_atual);
        end
        for (int i = 0; i < 5; i++) vote(3'(i + 1));
`endif
        wait_pronto(n);
        checks++;
        if (pronto !== 1'b1 || eliminado !== 3'd0) begin
            errors++;
            $display("FAIL t6_result pronto=%b elim=%0d want 1 0", pronto, eliminado);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            logic [4:0] v;
            int alive[$];
            int mt[6];
            int k, guard, t, n, mx, cnt, arg;
            bit ok;
            v = 5'($urandom_range(0, 31));
            alive.delete();
            for (int i = 1; i <= N; i++) if (v[i-1]) alive.push_back(i);
            foreach (mt[i]) mt[i] = 0;
            start(v);
            checks++;
            if (pronto !== (v == 5'd0)) begin
                errors++;
                $display("FAIL rnd_start_pronto r=%0d got %b want %b", r, pronto, v == 5'd0);
            end
            k = 0;
            guard = 0;
            while (k < alive.size() && guard < 100) begin
                guard++;
                if ($urandom_range(0, 3) != 0) t = alive[$urandom_range(0, alive.size() - 1)];
                else t = int'($urandom_range(0, 7));
                ok = 1'b0;
                if (t >= 1 && t <= N) ok = v[t-1];
`ifdef POLILOBINHO_ABSTENCAO_EN
                if (t == 0) ok = 1'b1;
`endif
                if ($urandom_range(0, 3) == 0) cyc();
                checks++;
                if (eleitor_atual !== 3'(alive[k])) begin
                    errors++;
                    $display("FAIL rnd_eleitor r=%0d got %0d want %0d", r, eleitor_atual, alive[k]);
                end
                vote(3'(t));
                checks++;
                if (voto_invalido !== !ok) begin
                    errors++;
                    $display("FAIL rnd_invalid r=%0d t=%0d got %b want %b", r, t, voto_invalido, !ok);
                end
                if (ok) begin
                    if (t != 0 && mt[t] < 7) mt[t]++;
                    k++;
                end
            end
            wait_pronto(n);
            checks++;
            if (pronto !== 1'b1) begin
                errors++;
                $display("FAIL rnd_timeout r=%0d pronto=%b want 1", r, pronto);
            end
            mx = 0;
            arg = 0;
            cnt = 0;
            for (int i = 1; i <= N; i++) if (mt[i] > mx) begin mx = mt[i]; arg = i; end
            for (int i = 1; i <= N; i++) if (mx > 0 && mt[i] == mx) cnt++;
            checks++;
            if (eliminado !== 3'((cnt == 1) ? arg : 0) || empate !== (cnt > 1) ||
                votos_max !== 3'(mx)) begin
                errors++;
                $display("FAIL rnd_result r=%0d elim=%0d emp=%b max=%0d want %0d %b %0d", r,
                         eliminado, empate, votos_max, (cnt == 1) ? arg : 0, cnt > 1, mx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_majority();
        test_tie();
        test_invalid();
        test_restart_and_reset();
        test_nobody_alive();
        test_abstention();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
